// File: rtl/blink_sequencer.sv
// Multi-channel LED blink controller: one shared tick prescaler drives per-channel
// OFF / ON / BLINK / counted-BURST behaviour, commanded over a valid/ready port.
module blink_sequencer #(
   parameter  int CLK_FREQ = 25_000_000,
   parameter  int TICK_HZ  = 2,
   parameter  int NUM_CH   = 4,
   parameter  int CNT_W    = 4,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iCmdValid,
   output logic              oCmdReady,
   input  logic [CH_W-1:0]   iCmdCh,
   input  logic [1:0]        iCmdMode,
   input  logic [CNT_W-1:0]  iCmdCount,
   output logic [NUM_CH-1:0] oBlink,
   output logic [NUM_CH-1:0] oDone,
   output logic              oTick
);

   localparam int PERIOD = CLK_FREQ / TICK_HZ;
   localparam int PRE_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PERIOD - 1);
   localparam logic [CNT_W:0]   REM_ONE  = (CNT_W+1)'(1);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   typedef enum logic [1:0] {ST_OFF, ST_ON, ST_BLINK, ST_BURST} chState_t;

   logic [PRE_W-1:0]  preCnt;
   logic              tick;
   chState_t          chState  [NUM_CH];
   chState_t          stateNxt [NUM_CH];
   logic [CNT_W:0]    rem      [NUM_CH];
   logic [CNT_W:0]    remNxt   [NUM_CH];
   logic [NUM_CH-1:0] blinkQ, blinkNxt;
   logic [NUM_CH-1:0] doneQ, doneNxt;
   logic [NUM_CH-1:0] hit;
   logic              tgtBurst;
   logic              accept;

   // Shared prescaler; the tick is registered so it lands the cycle after the wrap value
   always_ff @(posedge iClk) begin
      if (iRst) begin
         preCnt <= '0;
         tick   <= 1'b0;
      end else begin
         tick   <= (preCnt == PRE_LAST);
         preCnt <= (preCnt == PRE_LAST) ? '0 : preCnt + PRE_W'(1);
      end
   end

   assign oTick = tick;

   // Stall non-OFF commands aimed at a bursting channel; OFF always gets through to abort
   always_comb begin
      tgtBurst = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if ((iCmdCh == CH_W'(ch)) && (chState[ch] == ST_BURST)) tgtBurst = 1'b1;
      end
   end

   assign oCmdReady = !(iCmdValid && tgtBurst && (iCmdMode != MODE_OFF));
   assign accept    = iCmdValid && oCmdReady;

   always_comb begin
      hit = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         hit[ch] = accept && (iCmdCh == CH_W'(ch));
      end
   end

   // State register
   always_ff @(posedge iClk) begin
      if (iRst) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            chState[ch] <= ST_OFF;
            rem[ch]     <= '0;
         end
         blinkQ <= '0;
         doneQ  <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            chState[ch] <= stateNxt[ch];
            rem[ch]     <= remNxt[ch];
         end
         blinkQ <= blinkNxt;
         doneQ  <= doneNxt;
      end
   end

   // Next state: an accepted command overrides a coincident tick for its channel
   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         stateNxt[ch] = chState[ch];
         remNxt[ch]   = rem[ch];
         if (hit[ch]) begin
            remNxt[ch] = '0;
            case (iCmdMode)
               MODE_OFF:   stateNxt[ch] = ST_OFF;
               MODE_ON:    stateNxt[ch] = ST_ON;
               MODE_BLINK: stateNxt[ch] = ST_BLINK;
               MODE_BURST: begin
                  if (iCmdCount == '0) begin
                     stateNxt[ch] = ST_OFF;
                  end else begin
                     stateNxt[ch] = ST_BURST;
                     remNxt[ch]   = {iCmdCount, 1'b0};
                  end
               end
               default:    stateNxt[ch] = ST_OFF;
            endcase
         end else if (tick && (chState[ch] == ST_BURST)) begin
            if (rem[ch] == REM_ONE) begin
               stateNxt[ch] = ST_OFF;
               remNxt[ch]   = '0;
            end else begin
               remNxt[ch]   = rem[ch] - REM_ONE;
            end
         end
      end
   end

   // Outputs: blink level and burst-complete pulse
   always_comb begin
      blinkNxt = blinkQ;
      doneNxt  = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (hit[ch]) begin
            blinkNxt[ch] = (iCmdMode != MODE_OFF) &&
                           !((iCmdMode == MODE_BURST) && (iCmdCount == '0));
         end else if (tick) begin
            if (chState[ch] == ST_BLINK) begin
               blinkNxt[ch] = !blinkQ[ch];
            end else if (chState[ch] == ST_BURST) begin
               if (rem[ch] == REM_ONE) begin
                  blinkNxt[ch] = 1'b0;
                  doneNxt[ch]  = 1'b1;
               end else begin
                  blinkNxt[ch] = !blinkQ[ch];
               end
            end
         end
      end
   end

   assign oBlink = blinkQ;
   assign oDone  = doneQ;

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer: directed scenarios plus random commands, every cycle
// compared against a tick-counting behavioural model of the channels.
module tb_blink_sequencer;

   localparam int CLK_FREQ = 20;
   localparam int TICK_HZ  = 2;
   localparam int P        = CLK_FREQ / TICK_HZ;
   // Five channels give a 3-bit channel field, so nonexistent channel 5 is addressable
   localparam int NUM_CH   = 5;
   localparam int CNT_W    = 4;
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam int M_OFF   = 0;
   localparam int M_ON    = 1;
   localparam int M_BLINK = 2;
   localparam int M_BURST = 3;

   logic              iClk = 1'b0;
   logic              iRst = 1'b1;
   logic              iCmdValid = 1'b0;
   logic              oCmdReady;
   logic [CH_W-1:0]   iCmdCh = '0;
   logic [1:0]        iCmdMode = '0;
   logic [CNT_W-1:0]  iCmdCount = '0;
   logic [NUM_CH-1:0] oBlink;
   logic [NUM_CH-1:0] oDone;
   logic              oTick;

   blink_sequencer #(
      .CLK_FREQ(CLK_FREQ),
      .TICK_HZ (TICK_HZ),
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W)
   ) dut (
      .iClk     (iClk),
      .iRst     (iRst),
      .iCmdValid(iCmdValid),
      .oCmdReady(oCmdReady),
      .iCmdCh   (iCmdCh),
      .iCmdMode (iCmdMode),
      .iCmdCount(iCmdCount),
      .oBlink   (oBlink),
      .oDone    (oDone),
      .oTick    (oTick)
   );

   always #5 iClk = ~iClk;

   int nChecks = 0;
   int nBad    = 0;

   // Reference model: channel mode, level and ticks left in a burst; time as cycles since reset
   int   mAge;
   int   mMode [NUM_CH];
   logic mLvl  [NUM_CH];
   int   mLeft [NUM_CH];
   logic mDone [NUM_CH];

   int   sampleNo  = 0;
   int   lastTick  = -1;
   int   doneCnt [NUM_CH];
   int   rises   [NUM_CH];
   logic [NUM_CH-1:0] prevBlink = '0;
   logic lastAcc = 1'b0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic mdlReset();
      for (int c = 0; c < NUM_CH; c++) begin
         mMode[c] = M_OFF;
         mLvl[c]  = 1'b0;
         mLeft[c] = 0;
         mDone[c] = 1'b0;
      end
      mAge = 0;
   endtask

   // One clock: compare at the falling edge, advance the model, return just after the rising edge
   task automatic cycle();
      logic              mTick, mRdy, acc;
      logic [NUM_CH-1:0] expBlink, expDone;
      int                tc;
      @(negedge iClk);
      mTick = (mAge > 0) && (mAge % P == 0);
      tc    = int'(iCmdCh);
      mRdy  = 1'b1;
      if (iCmdValid && tc < NUM_CH && iCmdMode != 2'd0) begin
         if (mMode[tc] == M_BURST) mRdy = 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         expBlink[c] = mLvl[c];
         expDone[c]  = mDone[c];
      end
      checkVal("tick", oTick, mTick);
      checkVal("ready", oCmdReady, mRdy);
      checkVal("blink", oBlink, expBlink);
      checkVal("done", oDone, expDone);

      if (oTick) begin
         if (lastTick >= 0) checkVal("tick_period", sampleNo - lastTick, P);
         lastTick = sampleNo;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (oDone[c]) doneCnt[c]++;
         if (oBlink[c] && !prevBlink[c]) rises[c]++;
      end
      prevBlink = oBlink;
      sampleNo++;

      acc = iCmdValid && mRdy;
      if (iRst) begin
         mdlReset();
         lastTick = -1;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            mDone[c] = 1'b0;
            if (acc && tc == c) begin
               mLeft[c] = 0;
               case (iCmdMode)
                  2'd0: begin mMode[c] = M_OFF;   mLvl[c] = 1'b0; end
                  2'd1: begin mMode[c] = M_ON;    mLvl[c] = 1'b1; end
                  2'd2: begin mMode[c] = M_BLINK; mLvl[c] = 1'b1; end
                  default: begin
                     if (iCmdCount == '0) begin
                        mMode[c] = M_OFF;
                        mLvl[c]  = 1'b0;
                     end else begin
                        mMode[c] = M_BURST;
                        mLvl[c]  = 1'b1;
                        mLeft[c] = 2 * int'(iCmdCount);
                     end
                  end
               endcase
            end else if (mTick) begin
               if (mMode[c] == M_BLINK) begin
                  mLvl[c] = !mLvl[c];
               end else if (mMode[c] == M_BURST) begin
                  mLeft[c]--;
                  if (mLeft[c] == 0) begin
                     mMode[c] = M_OFF;
                     mLvl[c]  = 1'b0;
                     mDone[c] = 1'b1;
                  end else begin
                     mLvl[c] = !mLvl[c];
                  end
               end
            end
         end
         mAge++;
      end
      lastAcc = !iRst && acc;
      @(posedge iClk);
      #1;
   endtask

   task automatic idle(input int n);
      iCmdValid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic sendCmd(input int ch, input int mode, input int cnt, output int waited);
      iCmdValid = 1'b1;
      iCmdCh    = CH_W'(ch);
      iCmdMode  = 2'(mode);
      iCmdCount = CNT_W'(cnt);
      waited    = 0;
      lastAcc   = 1'b0;
      while (!lastAcc && waited < 200) begin
         cycle();
         waited++;
      end
      iCmdValid = 1'b0;
      if (!lastAcc) checkVal("cmd_accept_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      logic [NUM_CH-1:0] snap;
      int d2;

      for (int c = 0; c < NUM_CH; c++) begin
         doneCnt[c] = 0;
         rises[c]   = 0;
      end
      mdlReset();
      iRst = 1'b1;
      repeat (2) @(posedge iClk);
      #1;
      iRst = 1'b0;

      // Reset state and tick cadence
      checkVal("rst_blink", oBlink, 0);
      checkVal("rst_done", oDone, 0);
      checkVal("rst_tick", oTick, 0);
      checkVal("rst_ready", oCmdReady, 1);
      idle(35);

      // Continuous blink on channel 1
      sendCmd(1, M_BLINK, 0, w);
      checkVal("ch1_blink_on", oBlink[1], 1);
      checkVal("ch1_others_off", oBlink & 5'b11101, 0);
      idle(30);

      // Burst of 3 on channel 2, with an ON command stalled behind it
      rises[2] = 0;
      sendCmd(2, M_BURST, 3, w);
      checkVal("burst_start_hi", oBlink[2], 1);
      sendCmd(2, M_ON, 0, w);
      checkVal("burst_stalled", (w > 5 * P) ? 1 : 0, 1);
      checkVal("burst_done_cnt", doneCnt[2], 1);
      checkVal("burst_high_phases", rises[2], 3);
      checkVal("on_after_burst", oBlink[2], 1);
      idle(3);

      // OFF aborts a running burst at once, without a done pulse
      sendCmd(2, M_BURST, 5, w);
      idle(15);
      d2 = doneCnt[2];
      sendCmd(2, M_OFF, 0, w);
      checkVal("off_abort_imm", w, 1);
      checkVal("off_abort_low", oBlink[2], 0);
      idle(60);
      checkVal("off_abort_nodone", doneCnt[2], d2);

      // BLINK accepted in a tick cycle: tick ignored, toggles on the next one
      while (!((mAge > 0) && (mAge % P == 0))) cycle();
      sendCmd(0, M_BLINK, 0, w);
      checkVal("tick_coincide_hi", oBlink[0], 1);
      idle(P);
      checkVal("tick_coincide_next", oBlink[0], 0);

      // Command to a nonexistent channel is swallowed
      snap = oBlink;
      sendCmd(5, M_ON, 0, w);
      checkVal("bad_ch_ready", w, 1);
      checkVal("bad_ch_nochange", oBlink, snap);

      // BURST of zero acts as OFF
      sendCmd(3, M_ON, 0, w);
      idle(2);
      sendCmd(3, M_BURST, 0, w);
      checkVal("burst0_off", oBlink[3], 0);
      idle(30);
      checkVal("burst0_nodone", doneCnt[3], 0);

      // Reset in the middle of a long burst
      sendCmd(3, M_BURST, 7, w);
      idle(25);
      iRst = 1'b1;
      cycle();
      iRst = 1'b0;
      checkVal("midrst_blink", oBlink, 0);
      checkVal("midrst_done", oDone, 0);
      repeat (P - 1) cycle();
      checkVal("midrst_tick_early", oTick, 0);
      cycle();
      checkVal("midrst_tick_on_time", oTick, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         iRst      = ($urandom_range(299) == 0);
         iCmdValid = ($urandom_range(3) == 0);
         iCmdCh    = CH_W'($urandom_range(NUM_CH + 2));
         iCmdMode  = 2'($urandom_range(3));
         iCmdCount = CNT_W'($urandom_range(3));
         cycle();
      end
      iRst = 1'b0;
      idle(40);

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
